// File: rtl/pbch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pbch_pkg
// Description : Shared constants, state encoding and Gold-sequence helper
//               for the PBCH descrambler and related scrambling blocks.
// Revision    : 1.0 - initial release
// ============================================================================
package pbch_pkg;

  localparam int NC         = 1600;
  localparam int M_BIT_PBCH = 864;
  localparam int GOLD_LEN   = 31;

  // Feedback taps: x1(n+31) = x1(n+3)^x1(n); x2(n+31) = x2(n+3)^x2(n+2)^x2(n+1)^x2(n)
  localparam logic [GOLD_LEN-1:0] X1_TAP_MASK = 31'h0000_0009;
  localparam logic [GOLD_LEN-1:0] X2_TAP_MASK = 31'h0000_000F;

  typedef enum logic [1:0] {
    NO_ID     = 2'd0,
    WAIT_IBAR = 2'd1,
    INIT      = 2'd2,
    RUN       = 2'd3
  } pbch_state_e;

  // One LFSR step: bit 0 holds the oldest sample x(n); the new sample enters at the top.
  function automatic logic [GOLD_LEN-1:0] gold_step(input logic [GOLD_LEN-1:0] x,
                                                    input logic [GOLD_LEN-1:0] mask);
    return {^(x & mask), x[GOLD_LEN-1:1]};
  endfunction

endpackage
`default_nettype wire

// File: rtl/gold_seq_gen.sv
`default_nettype none
// ============================================================================
// Module      : gold_seq_gen
// Description : 31-bit Gold sequence generator (x1/x2 LFSR pair). Supports a
//               seed load, a multi-step fast advance and a single step; c_o
//               is the current sequence bit c(n) = x1(n) ^ x2(n).
// Revision    : 1.0 - initial release
// ============================================================================
module gold_seq_gen
  import pbch_pkg::*;
#(
  parameter int ADV_PER_CYCLE = 8
) (
  input  logic                clk_i,
  input  logic                reset_i,
  input  logic                load_i,
  input  logic [GOLD_LEN-1:0] seed_i,
  input  logic                adv_i,
  input  logic                step_i,
  output logic                c_o
);

  logic [GOLD_LEN-1:0] x1_q, x1_d;
  logic [GOLD_LEN-1:0] x2_q, x2_d;

  // Next LFSR contents: load has priority, then fast advance, then single step
  always_comb begin
    x1_d = x1_q;
    x2_d = x2_q;
    if (load_i) begin
      x1_d = {{(GOLD_LEN-1){1'b0}}, 1'b1};
      x2_d = seed_i;
    end else if (adv_i) begin
      for (int i = 0; i < ADV_PER_CYCLE; i++) begin
        x1_d = gold_step(x1_d, X1_TAP_MASK);
        x2_d = gold_step(x2_d, X2_TAP_MASK);
      end
    end else if (step_i) begin
      x1_d = gold_step(x1_q, X1_TAP_MASK);
      x2_d = gold_step(x2_q, X2_TAP_MASK);
    end
  end

  // LFSR state registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      x1_q <= '0;
      x2_q <= '0;
    end else begin
      x1_q <= x1_d;
      x2_q <= x2_d;
    end
  end

  assign c_o = x1_q[0] ^ x2_q[0];

endmodule
`default_nettype wire

// File: rtl/pbch_descrambler.sv
`default_nettype none
// ============================================================================
// Module      : pbch_descrambler
// Description : Removes the PBCH Gold scrambling from the demapper LLR
//               stream. c_init = N_id, sequence offset 1600 + v*864.
//               Optional macro PBCH_DESCR_DEBUG_EN adds saturating
//               drop_cnt_o / err_cnt_o debug counters.
// Revision    : 1.0 - initial release
// ============================================================================
module pbch_descrambler
  import pbch_pkg::*;
#(
  parameter int LLR_DW        = 8,
  parameter int N_ID_DW       = 10,
  parameter int L_MAX         = 4,
  parameter int ADV_PER_CYCLE = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [N_ID_DW-1:0] N_id_i,
  input  logic              N_id_valid_i,
  input  logic [2:0]        ibar_SSB_i,
  input  logic              ibar_SSB_valid_i,
  input  logic [LLR_DW-1:0] s_axis_llr_tdata,
  input  logic [1:0]        s_axis_llr_tuser,
  input  logic              s_axis_llr_tlast,
  input  logic              s_axis_llr_tvalid,
  output logic [LLR_DW-1:0] m_axis_llr_tdata,
  output logic [1:0]        m_axis_llr_tuser,
  output logic              m_axis_llr_tlast,
  output logic              m_axis_llr_tvalid,
  output logic              ready_o,
  output logic              block_err_o
`ifdef PBCH_DESCR_DEBUG_EN
  ,
  output logic [15:0]       drop_cnt_o,
  output logic [15:0]       err_cnt_o
`endif
);

  localparam logic [9:0]        LAST_K  = 10'(M_BIT_PBCH - 1);
  localparam logic [LLR_DW-1:0] LLR_MIN = {1'b1, {(LLR_DW-1){1'b0}}};
  localparam logic [LLR_DW-1:0] LLR_MAX = {1'b0, {(LLR_DW-1){1'b1}}};

  pbch_state_e        state_q, state_d;
  logic [N_ID_DW-1:0] nid_q, nid_d;
  logic [2:0]         v_q, v_d;
  logic [12:0]        cnt_q, cnt_d;
  logic               loaded_q, loaded_d;
  logic [9:0]         k_q, k_d;
  logic [LLR_DW-1:0]  tdata_q, tdata_d;
  logic [1:0]         tuser_q, tuser_d;
  logic               tlast_q, tlast_d;
  logic               tvalid_q, tvalid_d;
  logic               block_err_q, block_err_d;

  logic               gen_load, gen_adv, gen_step, c_bit, accept;
  logic [2:0]         v_sel;
  logic [12:0]        t_target;
  logic [LLR_DW-1:0]  llr_neg;

  assign v_sel    = (L_MAX == 8) ? ibar_SSB_i : {1'b0, ibar_SSB_i[1:0]};
  assign t_target = 13'(NC) + 13'(v_q) * 13'(M_BIT_PBCH);
  assign accept   = s_axis_llr_tvalid && (state_q == RUN);
  assign llr_neg  = (s_axis_llr_tdata == LLR_MIN) ? LLR_MAX : -s_axis_llr_tdata;

  gold_seq_gen #(
    .ADV_PER_CYCLE (ADV_PER_CYCLE)
  ) u_gold (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .load_i  (gen_load),
    .seed_i  ({{(GOLD_LEN-N_ID_DW){1'b0}}, nid_q}),
    .adv_i   (gen_adv),
    .step_i  (gen_step),
    .c_o     (c_bit)
  );

  // Control FSM: seed capture, fast-forward to the sequence offset, per-LLR stepping
  always_comb begin
    state_d     = state_q;
    nid_d       = nid_q;
    v_d         = v_q;
    cnt_d       = cnt_q;
    loaded_d    = loaded_q;
    k_d         = k_q;
    block_err_d = 1'b0;
    gen_load    = 1'b0;
    gen_adv     = 1'b0;
    gen_step    = 1'b0;

    if (N_id_valid_i) nid_d = N_id_i;

    case (state_q)
      NO_ID: begin
        if (N_id_valid_i) state_d = WAIT_IBAR;
      end
      WAIT_IBAR: begin
        if (ibar_SSB_valid_i) begin
          v_d      = v_sel;
          loaded_d = 1'b0;
          state_d  = INIT;
        end
      end
      INIT: begin
        // First INIT cycle seeds the LFSRs; the rest fast-forward to the offset.
        if (!loaded_q) begin
          gen_load = 1'b1;
          loaded_d = 1'b1;
          cnt_d    = '0;
        end else begin
          gen_adv = 1'b1;
          cnt_d   = cnt_q + 13'(ADV_PER_CYCLE);
          if (cnt_d == t_target) begin
            k_d     = '0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (s_axis_llr_tvalid) begin
          gen_step = 1'b1;
          k_d      = k_q + 10'd1;
          if (s_axis_llr_tlast || (k_q == LAST_K)) begin
            block_err_d = s_axis_llr_tlast != (k_q == LAST_K);
            state_d     = WAIT_IBAR;
            // A new SSB index arriving on the block end starts the next init directly.
            if (ibar_SSB_valid_i) begin
              v_d      = v_sel;
              loaded_d = 1'b0;
              state_d  = INIT;
            end
          end
        end
      end
      default: state_d = NO_ID;
    endcase
  end

  // Output stage: conditional saturated negation, sideband delayed alongside
  always_comb begin
    tvalid_d = accept;
    tdata_d  = '0;
    tuser_d  = '0;
    tlast_d  = 1'b0;
    if (accept) begin
      tdata_d = c_bit ? llr_neg : s_axis_llr_tdata;
      tuser_d = s_axis_llr_tuser;
      tlast_d = s_axis_llr_tlast;
    end
  end

  // State and output registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q     <= NO_ID;
      nid_q       <= '0;
      v_q         <= '0;
      cnt_q       <= '0;
      loaded_q    <= 1'b0;
      k_q         <= '0;
      tdata_q     <= '0;
      tuser_q     <= '0;
      tlast_q     <= 1'b0;
      tvalid_q    <= 1'b0;
      block_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      nid_q       <= nid_d;
      v_q         <= v_d;
      cnt_q       <= cnt_d;
      loaded_q    <= loaded_d;
      k_q         <= k_d;
      tdata_q     <= tdata_d;
      tuser_q     <= tuser_d;
      tlast_q     <= tlast_d;
      tvalid_q    <= tvalid_d;
      block_err_q <= block_err_d;
    end
  end

  assign m_axis_llr_tdata  = tdata_q;
  assign m_axis_llr_tuser  = tuser_q;
  assign m_axis_llr_tlast  = tlast_q;
  assign m_axis_llr_tvalid = tvalid_q;
  assign ready_o           = (state_q == RUN);
  assign block_err_o       = block_err_q;

`ifdef PBCH_DESCR_DEBUG_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;
  logic [15:0] err_cnt_q, err_cnt_d;

  // Saturating counters of dropped LLRs and block errors
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    err_cnt_d  = err_cnt_q;
    if (s_axis_llr_tvalid && (state_q != RUN) && (drop_cnt_q != 16'hFFFF))
      drop_cnt_d = drop_cnt_q + 16'd1;
    if (block_err_d && (err_cnt_q != 16'hFFFF))
      err_cnt_d = err_cnt_q + 16'd1;
  end

  // Debug counter registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      drop_cnt_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      drop_cnt_q <= drop_cnt_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign drop_cnt_o = drop_cnt_q;
  assign err_cnt_o  = err_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pbch_descrambler.sv
`default_nettype none
// ============================================================================
// Module      : tb_pbch_descrambler
// Description : Scoreboard bench for pbch_descrambler with an independent
//               array-based Gold sequence model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pbch_descrambler;

  localparam int GN = 8600;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic [9:0] N_id_i = '0;
  logic       N_id_valid_i = 1'b0;
  logic [2:0] ibar_SSB_i = '0;
  logic       ibar_SSB_valid_i = 1'b0;
  logic [7:0] s_tdata = '0;
  logic [1:0] s_tuser = '0;
  logic       s_tlast = 1'b0;
  logic       s_tvalid = 1'b0;
  logic [7:0] m_tdata;
  logic [1:0] m_tuser;
  logic       m_tlast;
  logic       m_tvalid;
  logic       ready_o;
  logic       block_err_o;
`ifdef PBCH_DESCR_DEBUG_EN
  logic [15:0] drop_cnt_o;
  logic [15:0] err_cnt_o;
`endif

  int checks = 0;
  int failures = 0;
  int err_seen = 0;
  int err_exp = 0;
  logic [10:0] sb_q[$];
  bit x1g[GN];
  bit x2g[GN];

  pbch_descrambler dut (
    .clk_i             (clk),
    .reset_i           (reset_i),
    .N_id_i            (N_id_i),
    .N_id_valid_i      (N_id_valid_i),
    .ibar_SSB_i        (ibar_SSB_i),
    .ibar_SSB_valid_i  (ibar_SSB_valid_i),
    .s_axis_llr_tdata  (s_tdata),
    .s_axis_llr_tuser  (s_tuser),
    .s_axis_llr_tlast  (s_tlast),
    .s_axis_llr_tvalid (s_tvalid),
    .m_axis_llr_tdata  (m_tdata),
    .m_axis_llr_tuser  (m_tuser),
    .m_axis_llr_tlast  (m_tlast),
    .m_axis_llr_tvalid (m_tvalid),
    .ready_o           (ready_o),
    .block_err_o       (block_err_o)
`ifdef PBCH_DESCR_DEBUG_EN
    ,
    .drop_cnt_o        (drop_cnt_o),
    .err_cnt_o         (err_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference Gold sequence straight from the recursion definition
  task automatic gold_fill(input int nid);
    for (int n = 0; n < 31; n++) begin
      x1g[n] = (n == 0);
      x2g[n] = ((nid >> n) & 1) != 0;
    end
    for (int n = 0; n + 31 < GN; n++) begin
      x1g[n+31] = x1g[n+3] ^ x1g[n];
      x2g[n+31] = x2g[n+3] ^ x2g[n+2] ^ x2g[n+1] ^ x2g[n];
    end
  endtask

  function automatic logic [7:0] exp_llr(input logic [7:0] x, input bit c);
    if (!c) return x;
    if (x == 8'h80) return 8'h7F;
    return 8'(-x);
  endfunction

  // Output monitor: every DUT output must match the next scoreboard entry
  always @(negedge clk) begin
    if (!reset_i) begin
      if (block_err_o) err_seen++;
      if (m_tvalid) begin
        if (sb_q.size() == 0) begin
          check_val("unexpected_out", {21'd0, m_tdata, m_tuser, m_tlast}, 32'hFFFF_FFFF);
        end else begin
          check_val("out_llr", {21'd0, m_tdata, m_tuser, m_tlast}, {21'd0, sb_q.pop_front()});
        end
      end
    end
  end

  task automatic pulse_nid(input int nid);
    N_id_i = 10'(nid);
    N_id_valid_i = 1'b1;
    tick();
    N_id_valid_i = 1'b0;
  endtask

  // Pulse ibar (optionally with a new N_id in the same cycle) and time INIT
  task automatic start_init(input int ibar, input bit with_nid, input int nid, input string tag);
    int n;
    int v;
    v = ibar & 3;
    ibar_SSB_i = 3'(ibar);
    ibar_SSB_valid_i = 1'b1;
    if (with_nid) begin
      N_id_i = 10'(nid);
      N_id_valid_i = 1'b1;
    end
    tick();
    ibar_SSB_valid_i = 1'b0;
    N_id_valid_i = 1'b0;
    n = 1;
    while (!ready_o && n < 2000) begin
      tick();
      n++;
    end
    check_val(tag, 32'(n - 1), 32'((1600 + v * 864) / 8 + 1));
  endtask

  // Drive LLRs 0..stop_at-1 of a block at Gold offset base, pushing expectations
  task automatic drive_block(input int base, input int mode, input int tlast_idx, input int stop_at);
    logic [7:0] d;
    bit c;
    for (int i = 0; i < stop_at; i++) begin
      case (mode)
        0: d = 8'd100;
        1: d = 8'h80;
        default: d = (i % 37 == 0) ? 8'h80 : 8'($urandom_range(0, 255));
      endcase
      c = x1g[base+i] ^ x2g[base+i];
      s_tdata  = d;
      s_tuser  = 2'(i);
      s_tlast  = (i == tlast_idx);
      s_tvalid = 1'b1;
      sb_q.push_back({exp_llr(d, c), 2'(i), (i == tlast_idx)});
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic drop_llrs(input int n);
    for (int i = 0; i < n; i++) begin
      s_tdata  = 8'($urandom_range(0, 255));
      s_tuser  = 2'(i);
      s_tlast  = (i == n - 1);
      s_tvalid = 1'b1;
      tick();
    end
    s_tvalid = 1'b0;
    s_tlast  = 1'b0;
  endtask

  task automatic block_done(input string tag);
    tick();
    tick();
    tick();
    check_val({tag, "_sb_empty"}, 32'(sb_q.size()), 32'd0);
    check_val({tag, "_err_cnt"}, 32'(err_seen), 32'(err_exp));
    check_val({tag, "_ready_low"}, {31'd0, ready_o}, 32'd0);
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    check_val("rst_outputs", {21'd0, m_tdata, m_tuser, m_tlast}, 32'd0);
    check_val("rst_valid_ready_err", {29'd0, m_tvalid, ready_o, block_err_o}, 32'd0);
    reset_i = 1'b0;
    tick();

    // LLRs and an ibar before any N_id are ignored
    ibar_SSB_valid_i = 1'b1;
    tick();
    ibar_SSB_valid_i = 1'b0;
    drop_llrs(10);
    check_val("no_id_ready", {31'd0, ready_o}, 32'd0);

    // N_id = 0, v = 0, all +100
    gold_fill(0);
    pulse_nid(0);
    start_init(0, 1'b0, 0, "init_lat_v0");
    drive_block(1600, 0, 863, 864);
    block_done("blk_nid0");

    // N_id = 1007, ibar = 3, all -128 (saturation where c = 1)
    gold_fill(1007);
    pulse_nid(1007);
    start_init(3, 1'b0, 0, "init_lat_v3");
    drive_block(1600 + 3 * 864, 1, 863, 864);
    block_done("blk_nid1007");

    // N_id and ibar together in WAIT_IBAR; early tlast at index 500
    gold_fill(7);
    start_init(6, 1'b1, 7, "init_lat_v2_same");
    drive_block(1600 + 2 * 864, 2, 500, 501);
    err_exp++;
    drop_llrs(20);
    block_done("blk_early_tlast");
`ifdef PBCH_DESCR_DEBUG_EN
    check_val("dbg_drop_cnt", {16'd0, drop_cnt_o}, 32'd30);
    check_val("dbg_err_cnt", {16'd0, err_cnt_o}, 32'd1);
`endif

    // Reset in the middle of a block
    gold_fill(5);
    pulse_nid(5);
    start_init(1, 1'b0, 0, "init_lat_v1");
    drive_block(1600 + 864, 2, 863, 300);
    reset_i = 1'b1;
    sb_q.delete();
    #1;
    check_val("midrst_outputs", {21'd0, m_tdata, m_tuser, m_tlast}, 32'd0);
    check_val("midrst_valid_ready_err", {29'd0, m_tvalid, ready_o, block_err_o}, 32'd0);
    tick();
    tick();
    reset_i = 1'b0;
    tick();

    // After reset: nothing until both N_id and ibar are seen
    drop_llrs(10);
    pulse_nid(5);
    drop_llrs(10);
    check_val("post_rst_wait_ready", {31'd0, ready_o}, 32'd0);
    start_init(1, 1'b0, 0, "init_lat_post_rst");
    drive_block(1600 + 864, 2, 863, 864);
    block_done("blk_post_rst");

    // Full length without tlast is a block error
    start_init(2, 1'b0, 0, "init_lat_notlast");
    drive_block(1600 + 2 * 864, 2, -1, 864);
    err_exp++;
    block_done("blk_no_tlast");
`ifdef PBCH_DESCR_DEBUG_EN
    check_val("dbg_drop_cnt_post", {16'd0, drop_cnt_o}, 32'd20);
    check_val("dbg_err_cnt_post", {16'd0, err_cnt_o}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
